// File: rtl/unison_seq_ctrl_if.sv
// Control/readout bundle between the unison sequencer and its environment.
// The slave modport is the sequencer side; master is the driver/consumer side.
interface unison_seq_ctrl_if #(
  parameter int CH_W = 4
);
  logic            start;
  logic            stop;
  logic            adapt_en_cfg;
  logic [1:0]      read_out_I;
  logic [1:0]      read_out_Q;
  logic            rstb_core;
  logic            ud_en;
  logic [CH_W-1:0] ch_sel;
  logic            ch_en;
  logic            smp_valid;
  logic [CH_W-1:0] smp_ch;
  logic [3:0]      smp_data;
  logic            frame_done;
  logic [2:0]      state;

  modport slave (
    input  start, stop, adapt_en_cfg, read_out_I, read_out_Q,
    output rstb_core, ud_en, ch_sel, ch_en, smp_valid, smp_ch, smp_data,
           frame_done, state
  );

  modport master (
    output start, stop, adapt_en_cfg, read_out_I, read_out_Q,
    input  rstb_core, ud_en, ch_sel, ch_en, smp_valid, smp_ch, smp_data,
           frame_done, state
  );
endinterface

// File: rtl/unison_seq_ctrl.sv
// Run-time sequencer for the unison filterbank: core reset hold, timed
// adaptation window, then continuous slot-by-slot readout scan with tagged
// samples. Every output comes straight from a register.
module unison_seq_ctrl #(
  parameter int N_CH      = 16,
  parameter int CH_W      = 4,
  parameter int RST_CYC   = 8,
  parameter int ADAPT_CYC = 10008,
  parameter int SLOT_CYC  = 2
) (
  input logic              clk_master,
  input logic              rst,
  unison_seq_ctrl_if.slave bus
);

  localparam int SLOT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

  localparam logic [15:0]       RST_LAST   = 16'(RST_CYC - 1);
  localparam logic [15:0]       ADAPT_LAST = 16'(ADAPT_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
  localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RSTHOLD = 3'd1,
    ADAPT   = 3'd2,
    READ    = 3'd3
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic              ch_en_q, ch_en_d;
  logic              ud_en_q, ud_en_d;
  logic              rstb_q, rstb_d;
  logic              init_done_q, init_done_d;  // a full RSTHOLD has completed
  logic              smp_valid_q, smp_valid_d;
  logic [CH_W-1:0]   smp_ch_q, smp_ch_d;
  logic [3:0]        smp_data_q, smp_data_d;
  logic              frame_done_q, frame_done_d;

  // Next-state logic; registered outputs are derived from the next state so
  // they change on the same edge as the state they belong to.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    ch_sel_d     = ch_sel_q;
    init_done_d  = init_done_q;
    smp_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    smp_ch_d     = smp_ch_q;
    smp_data_d   = smp_data_q;

    if (state_q != IDLE && bus.stop) begin
      // Abort wins over every internal transition; the partial slot is dropped.
      state_d  = IDLE;
      cnt_d    = '0;
      slot_d   = '0;
      ch_sel_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_d = RSTHOLD;
            cnt_d   = '0;
          end
        end
        RSTHOLD: begin
          if (cnt_q == RST_LAST) begin
            init_done_d = 1'b1;
            cnt_d       = '0;
            slot_d      = '0;
            ch_sel_d    = '0;
            state_d     = bus.adapt_en_cfg ? ADAPT : READ;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ADAPT: begin
          if (cnt_q == ADAPT_LAST) begin
            cnt_d    = '0;
            slot_d   = '0;
            ch_sel_d = '0;
            state_d  = READ;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        READ: begin
          if (slot_q == SLOT_LAST) begin
            slot_d       = '0;
            smp_valid_d  = 1'b1;
            smp_ch_d     = ch_sel_q;
            smp_data_d   = {bus.read_out_Q, bus.read_out_I};
            frame_done_d = (ch_sel_q == CH_LAST);
            ch_sel_d     = (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + CH_W'(1);
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          slot_d   = '0;
          ch_sel_d = '0;
        end
      endcase
    end

    ud_en_d = (state_d == ADAPT);
    ch_en_d = (state_d == READ);
    // Cores stay in reset until the first hold completes; afterwards only
    // RSTHOLD pulls rstb_core low.
    if (state_d == RSTHOLD)   rstb_d = 1'b0;
    else if (state_d == IDLE) rstb_d = init_done_d;
    else                      rstb_d = 1'b1;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      slot_q       <= '0;
      ch_sel_q     <= '0;
      ch_en_q      <= 1'b0;
      ud_en_q      <= 1'b0;
      rstb_q       <= 1'b0;
      init_done_q  <= 1'b0;
      smp_valid_q  <= 1'b0;
      smp_ch_q     <= '0;
      smp_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      ch_sel_q     <= ch_sel_d;
      ch_en_q      <= ch_en_d;
      ud_en_q      <= ud_en_d;
      rstb_q       <= rstb_d;
      init_done_q  <= init_done_d;
      smp_valid_q  <= smp_valid_d;
      smp_ch_q     <= smp_ch_d;
      smp_data_q   <= smp_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.rstb_core  = rstb_q;
  assign bus.ud_en      = ud_en_q;
  assign bus.ch_sel     = ch_sel_q;
  assign bus.ch_en      = ch_en_q;
  assign bus.smp_valid  = smp_valid_q;
  assign bus.smp_ch     = smp_ch_q;
  assign bus.smp_data   = smp_data_q;
  assign bus.frame_done = frame_done_q;

endmodule
